// File: rtl/if_icache.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : if_icache
// Purpose  : Instruction-fetch stage with a direct-mapped, one-word-per-line
//            instruction cache. Misses are refilled one byte per handshake
//            from a byte-wide instruction memory port. A watchdog aborts a
//            refill whose memory stops answering.
// Options  : ICACHE_STATS_EN - adds hit_cnt / miss_cnt statistic outputs.
// Revision : 1.0 - initial release
// ============================================================================
module if_icache #(
  parameter int INDEX_W     = 6,
  parameter int MEM_LAT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] pc,
  input  logic        flush,
  input  logic        fence_i,
  input  logic        stall,
  output logic        hit,
  output logic        ifing,
  output logic [31:0] inst,
  output logic [31:0] inst_addr,
  output logic        inst_valid,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_data,
  input  logic        mem_ready,
`ifdef ICACHE_STATS_EN
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
`endif
  output logic        mem_timeout
);

  localparam int         C_LINES    = 1 << INDEX_W;
  localparam int         C_TAG_W    = 30 - INDEX_W;
  // Watchdog compares the count of ready-less REQ cycles already spent.
  localparam logic [7:0] C_WD_LIMIT = 8'(MEM_LAT_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2
  } state_t;

  // Cache storage: valid bits are reset, tag/data are plain storage.
  logic [C_LINES-1:0] valid_q, valid_d;
  logic [C_TAG_W-1:0] tag_mem  [C_LINES];
  logic [31:0]        data_mem [C_LINES];

  // Control and datapath registers
  state_t      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  wd_q, wd_d;
  logic [31:0] word_q, word_d;
  logic        ifing_q, ifing_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic        inst_valid_q, inst_valid_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        timeout_q, timeout_d;

  // Lookup address split; pc[1:0] does not take part in the lookup.
  logic [INDEX_W-1:0] w_idx;
  logic [C_TAG_W-1:0] w_tag;
  logic [INDEX_W-1:0] w_fill_idx;
  logic [C_TAG_W-1:0] w_fill_tag;
  logic               w_start;
  logic               w_line_we;
  logic               w_unused;

  assign w_idx      = pc[INDEX_W+1:2];
  assign w_tag      = pc[31:INDEX_W+2];
  assign w_fill_idx = base_q[INDEX_W+1:2];
  assign w_fill_tag = base_q[31:INDEX_W+2];
  assign w_unused   = &{1'b0, pc[1:0]};

  // Hit is combinational so the PC register can advance in the same cycle.
  assign hit = ce & (state_q == S_IDLE) & valid_q[w_idx] &
               (tag_mem[w_idx] == w_tag) & ~fence_i;

  // A refill starts on an enabled miss that is not being redirected or fenced.
  assign w_start = (state_q == S_IDLE) & ce & ~hit & ~flush & ~fence_i;

  // A line is written on the FILL cycle unless a flush discards the refill.
  assign w_line_we = (state_q == S_FILL) & ~flush;

  // Next-state and output computation for the fetch/refill controller.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    wd_d         = wd_q;
    word_d       = word_q;
    ifing_d      = ifing_q;
    inst_d       = inst_q;
    inst_addr_d  = inst_addr_q;
    inst_valid_d = stall ? inst_valid_q : 1'b0;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    timeout_d    = timeout_q;

    if (flush) begin
      // Redirect beats everything: drop output, abandon any partial refill.
      state_d      = S_IDLE;
      ifing_d      = 1'b0;
      mem_req_d    = 1'b0;
      inst_valid_d = 1'b0;
      cnt_d        = 2'd0;
      wd_d         = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hit && !stall) begin
            inst_d       = data_mem[w_idx];
            inst_addr_d  = {pc[31:2], 2'b00};
            inst_valid_d = 1'b1;
          end else if (w_start) begin
            base_d     = {pc[31:2], 2'b00};
            cnt_d      = 2'd0;
            wd_d       = 8'd0;
            state_d    = S_REQ;
            ifing_d    = 1'b1;
            mem_req_d  = 1'b1;
            mem_addr_d = {pc[31:2], 2'b00};
          end
        end

        S_REQ: begin
          if (fence_i) begin
            // Invalidation during a refill abandons it like a redirect.
            state_d      = S_IDLE;
            ifing_d      = 1'b0;
            mem_req_d    = 1'b0;
            inst_valid_d = 1'b0;
            cnt_d        = 2'd0;
            wd_d         = 8'd0;
          end else if (mem_ready) begin
            word_d[{cnt_q, 3'b000} +: 8] = mem_data;
            wd_d = 8'd0;
            if (cnt_q == 2'd3) begin
              state_d   = S_FILL;
              mem_req_d = 1'b0;
              cnt_d     = 2'd0;
            end else begin
              cnt_d      = cnt_q + 2'd1;
              mem_addr_d = {base_q[31:2], cnt_q + 2'd1};
            end
          end else if (wd_q == C_WD_LIMIT) begin
            // Memory stopped answering: flag it and give up on this line.
            timeout_d = 1'b1;
            state_d   = S_IDLE;
            ifing_d   = 1'b0;
            mem_req_d = 1'b0;
            cnt_d     = 2'd0;
            wd_d      = 8'd0;
          end else begin
            wd_d = wd_q + 8'd1;
          end
        end

        S_FILL: begin
          if (!stall) begin
            inst_d       = word_q;
            inst_addr_d  = base_q;
            inst_valid_d = 1'b1;
          end
          ifing_d = 1'b0;
          state_d = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Valid bits: a fence wipes every line, and wins over a same-cycle fill.
  always_comb begin
    valid_d = valid_q;
    if (fence_i) begin
      valid_d = '0;
    end else if (w_line_we) begin
      valid_d[w_fill_idx] = 1'b1;
    end
  end

  // Register the controller state, outputs and valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      base_q       <= 32'd0;
      cnt_q        <= 2'd0;
      wd_q         <= 8'd0;
      word_q       <= 32'd0;
      ifing_q      <= 1'b0;
      inst_q       <= 32'd0;
      inst_addr_q  <= 32'd0;
      inst_valid_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'd0;
      timeout_q    <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      wd_q         <= wd_d;
      word_q       <= word_d;
      ifing_q      <= ifing_d;
      inst_q       <= inst_d;
      inst_addr_q  <= inst_addr_d;
      inst_valid_q <= inst_valid_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      timeout_q    <= timeout_d;
      valid_q      <= valid_d;
    end
  end

  // Tag/data array write on a completed refill.
  always_ff @(posedge clk) begin
    if (w_line_we) begin
      tag_mem[w_fill_idx]  <= w_fill_tag;
      data_mem[w_fill_idx] <= word_q;
    end
  end

  assign ifing       = ifing_q;
  assign inst        = inst_q;
  assign inst_addr   = inst_addr_q;
  assign inst_valid  = inst_valid_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign mem_timeout = timeout_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Statistic counters: delivered hits and refill starts, free-running wrap.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit && !stall) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if (w_start) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  // Register the statistic counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_icache.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_if_icache
// Purpose  : Scoreboard bench for if_icache. A line-address cache model and a
//            byte memory model predict every delivered instruction and every
//            byte request; a monitor compares as the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_icache;
  localparam int INDEX_W     = 6;
  localparam int MEM_LAT_MAX = 8;
  localparam int LINES       = 1 << INDEX_W;

  logic        clk = 1'b0;
  logic        rst, ce, flush, fence_i, stall;
  logic [31:0] pc;
  logic        hit, ifing, inst_valid, mem_req, mem_timeout;
  logic [31:0] inst, inst_addr, mem_addr;
  logic [7:0]  mem_data  = 8'd0;
  logic        mem_ready = 1'b0;

  if_icache #(.INDEX_W(INDEX_W), .MEM_LAT_MAX(MEM_LAT_MAX)) dut (
    .clk(clk), .rst(rst), .ce(ce), .pc(pc), .flush(flush), .fence_i(fence_i),
    .stall(stall), .hit(hit), .ifing(ifing), .inst(inst), .inst_addr(inst_addr),
    .inst_valid(inst_valid), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ready(mem_ready), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
  } exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        sb_q[$];
  logic [31:0] maddr_q[$];
  bit          m_valid[LINES];
  logic [29:0] m_line[LINES];
  logic [7:0]  mem_ovr[logic [31:0]];
  bit          mem_auto  = 1'b1;
  int          mem_limit = -1;
  int          mem_given = 0;
  int          max_delay = 0;
  int          cur_delay = 0;
  int          wait_cnt  = 0;
  logic [31:0] last_inst = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Instruction memory contents: a few fixed bytes, otherwise a hash.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a[7:0] * 8'd29) ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] base);
    return {mem_byte(base + 32'd3), mem_byte(base + 32'd2),
            mem_byte(base + 32'd1), mem_byte(base)};
  endfunction

  // A line holds exactly one word; it hits when that word address is resident.
  function automatic bit model_hit(input logic [31:0] a);
    int idx;
    idx = int'(a[INDEX_W+1:2]);
    return m_valid[idx] && (m_line[idx] == a[31:2]);
  endfunction

  function automatic void model_fence();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endfunction

  // Monitor: every inst_valid pulse must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && inst_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_inst: got inst 0x%08h addr 0x%08h, none expected",
                 inst, inst_addr);
      end else begin
        e = sb_q.pop_front();
        chk("inst_data", inst, e.inst);
        chk("inst_addr", inst_addr, e.addr);
        last_inst = e.inst;
      end
    end
  end

  // Memory responder: random latency, checks each byte address served.
  always @(negedge clk) begin : memory
    mem_ready = 1'b0;
    if (!rst && mem_auto && mem_req && (mem_limit < 0 || mem_given < mem_limit)) begin
      if (wait_cnt >= cur_delay) begin
        mem_ready = 1'b1;
        mem_data  = mem_byte(mem_addr);
        if (maddr_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL mem_addr: request 0x%08h, none expected", mem_addr);
        end else begin
          chk("mem_addr", mem_addr, maddr_q.pop_front());
        end
        wait_cnt  = 0;
        cur_delay = int'($urandom_range(0, max_delay));
        mem_given++;
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic wait_refill();
    int n;
    n = 0;
    while (ifing === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) bound_fail("refill_wait");
  endtask

  // One fetch: present pc for a single cycle, predict hit/miss and delivery.
  task automatic access(input logic [31:0] a, input bit deliver, output bit was_hit);
    logic [31:0] base;
    bit          exp_hit;
    exp_t        e;
    int          idx;
    base    = {a[31:2], 2'b00};
    idx     = int'(a[INDEX_W+1:2]);
    exp_hit = model_hit(a);
    @(negedge clk);
    pc = a;
    ce = 1'b1;
    #1;
    chk("hit", {31'd0, hit}, {31'd0, exp_hit});
    was_hit = exp_hit;
    e.inst  = mem_word(base);
    e.addr  = base;
    if (exp_hit) begin
      if (deliver) sb_q.push_back(e);
      @(negedge clk);
      ce = 1'b0;
      chk("no_mem_req_on_hit", {31'd0, mem_req}, 32'd0);
    end else begin
      for (int i = 0; i < 4; i++) maddr_q.push_back(base + 32'(i));
      if (deliver) sb_q.push_back(e);
      m_valid[idx] = 1'b1;
      m_line[idx]  = a[31:2];
      @(negedge clk);
      ce = 1'b0;
      chk("ifing_refill", {31'd0, ifing}, 32'd1);
      wait_refill();
    end
  endtask

  task automatic pulse_fence();
    @(negedge clk);
    fence_i = 1'b1;
    @(negedge clk);
    fence_i = 1'b0;
    model_fence();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    n_errors++;
    n_checks++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : stim
    bit          h;
    int          n;
    logic [31:0] a;
    logic [31:0] pool[8];
    rst = 1'b1; ce = 1'b0; pc = 32'd0; flush = 1'b0; fence_i = 1'b0; stall = 1'b0;
    mem_ovr[32'h0] = 8'h13;
    mem_ovr[32'h1] = 8'h05;
    mem_ovr[32'h2] = 8'h10;
    mem_ovr[32'h3] = 8'h00;
    model_fence();
    pool = '{32'h0, 32'h4, 32'h100, 32'h104, 32'h40, 32'h3FC, 32'h13D, 32'h1002};

    repeat (3) @(negedge clk);
    chk("rst_ifing", {31'd0, ifing}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_timeout", {31'd0, mem_timeout}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_addr", inst_addr, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_hit", {31'd0, hit}, 32'd0);
    rst = 1'b0;

    // Cold miss then warm hit at 0x0: word 0x00100513
    access(32'h0, 1'b1, h);
    chk("cold_inst", inst, 32'h0010_0513);
    chk("cold_ifing_done", {31'd0, ifing}, 32'd0);
    access(32'h0, 1'b1, h);

    // Conflict at the same index replaces the line
    access(32'h100, 1'b1, h);
    access(32'h0, 1'b1, h);
    access(32'h100, 1'b1, h);

    // Flush after the second byte of a refill at 0x40
    mem_limit = mem_given + 2;
    @(negedge clk);
    pc = 32'h40;
    ce = 1'b1;
    #1;
    chk("flush_miss_hit", {31'd0, hit}, {31'd0, model_hit(32'h40)});
    maddr_q.push_back(32'h40);
    maddr_q.push_back(32'h41);
    @(negedge clk);
    ce = 1'b0;
    n = 0;
    while (mem_given < mem_limit && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (n >= 100) bound_fail("flush_setup");
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_mem_req", {31'd0, mem_req}, 32'd0);
    chk("flush_ifing", {31'd0, ifing}, 32'd0);
    chk("flush_inst_valid", {31'd0, inst_valid}, 32'd0);
    mem_limit = -1;
    access(32'h40, 1'b1, h);

    // fence_i invalidates both 0x0 and 0x4
    access(32'h4, 1'b1, h);
    access(32'h0, 1'b1, h);
    pulse_fence();
    access(32'h0, 1'b1, h);
    access(32'h4, 1'b1, h);

    // fence_i coincident with FILL: delivered, but line left invalid
    @(negedge clk);
    pc = 32'h80;
    ce = 1'b1;
    #1;
    chk("fencefill_hit", {31'd0, hit}, {31'd0, model_hit(32'h80)});
    for (int i = 0; i < 4; i++) maddr_q.push_back(32'h80 + 32'(i));
    sb_q.push_back({mem_word(32'h80), 32'h80});
    @(negedge clk);
    ce = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      #1;
      if (ifing && !mem_req) break;
      n++;
    end
    if (n >= 100) bound_fail("fencefill_wait");
    fence_i = 1'b1;
    @(negedge clk);
    fence_i = 1'b0;
    model_fence();
    chk("fencefill_delivered", {31'd0, inst_valid}, 32'd1);
    access(32'h80, 1'b1, h);

    // Stalled refill writes the line silently; next unstalled hit delivers
    @(negedge clk);
    stall = 1'b1;
    access(32'hC0, 1'b0, h);
    chk("stall_valid_low", {31'd0, inst_valid}, 32'd0);
    chk("stall_inst_hold", inst, last_inst);
    access(32'hC0, 1'b0, h);
    @(negedge clk);
    chk("stall_hit_no_valid", {31'd0, inst_valid}, 32'd0);
    stall = 1'b0;
    access(32'hC0, 1'b1, h);

    // Random traffic over a conflicting address pool
    for (int k = 0; k < 80; k++) begin
      max_delay = int'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) pulse_fence();
      n = int'($urandom_range(0, 9));
      if (n < 8) a = pool[n];
      else a = $urandom & 32'h0000_0FFF;
      access(a, 1'b1, h);
    end

    // Watchdog: memory never answers
    max_delay = 0;
    mem_auto  = 1'b0;
    @(negedge clk);
    pc = 32'hDEAD_0000;
    ce = 1'b1;
    #1;
    chk("to_hit", {31'd0, hit}, {31'd0, model_hit(32'hDEAD_0000)});
    @(negedge clk);
    ce = 1'b0;
    chk("to_mem_req_start", {31'd0, mem_req}, 32'd1);
    repeat (7) @(negedge clk);
    chk("to_not_yet", {31'd0, mem_timeout}, 32'd0);
    chk("to_req_held", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    chk("to_flag", {31'd0, mem_timeout}, 32'd1);
    chk("to_mem_req_drop", {31'd0, mem_req}, 32'd0);
    chk("to_ifing_drop", {31'd0, ifing}, 32'd0);
    repeat (3) @(negedge clk);
    chk("to_sticky", {31'd0, mem_timeout}, 32'd1);
    mem_auto = 1'b1;
    access(32'h0, 1'b1, h);
    access(32'h0, 1'b1, h);
    chk("to_sticky_end", {31'd0, mem_timeout}, 32'd1);

    repeat (5) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("maddr_drained", 32'(maddr_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
